// File: rtl/loopback_test_seq.sv
// SerDes link self-test sequencer: sweeps the GTX through up to four loopback modes
// and records each mode's error-counter delta and pass flag over a fixed window.
module loopback_test_seq #(
    parameter int SETTLE_CYC = 1024,
    parameter int WIN_CYC    = 65536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [3:0]  mode_en,
    input  logic [15:0] err_thresh,
    input  logic [15:0] data_err_cnt,
    input  logic [15:0] link_err_cnt,
    output logic [2:0]  gtx_loopback,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [3:0]  pass_mask,
    output logic [3:0]  tested_mask,
    output logic [63:0] err_res
);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_SETTLE, S_SNAP, S_WINDOW, S_EVAL, S_FINISH
    } state_t;

    state_t      state, state_next;
    logic [2:0]  idx;
    logic [31:0] timer;
    logic [15:0] snap_d, snap_l;
    logic [15:0] d_delta, l_delta;
    logic [2:0]  slot_mode;
    logic        settle_last, win_last, active;

    // Modulo-2^16 subtraction absorbs counter wrap inside the window.
    assign d_delta     = data_err_cnt - snap_d;
    assign l_delta     = link_err_cnt - snap_l;
    assign settle_last = (timer == 32'(SETTLE_CYC - 1));
    assign win_last    = (timer == 32'(WIN_CYC - 1));
    assign active      = (state != S_IDLE) && (state != S_FINISH);
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_FINISH);

    always_comb begin
        slot_mode = 3'b000;
        case (idx[1:0])
            2'd0: slot_mode = 3'b001;
            2'd1: slot_mode = 3'b010;
            2'd2: slot_mode = 3'b100;
            2'd3: slot_mode = 3'b110;
            default: slot_mode = 3'b000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (abort && active) begin
            state_next = S_FINISH;
        end else begin
            case (state)
                S_IDLE:   if (start && !abort) state_next = S_SELECT;
                S_SELECT: begin
                    if (idx[2])                 state_next = S_FINISH;
                    else if (mode_en[idx[1:0]]) state_next = S_SETTLE;
                end
                S_SETTLE: if (settle_last) state_next = S_SNAP;
                S_SNAP:   state_next = S_WINDOW;
                S_WINDOW: if (win_last) state_next = S_EVAL;
                S_EVAL:   state_next = S_SELECT;
                S_FINISH: state_next = S_IDLE;
                default:  state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= 3'd0;
            timer        <= 32'd0;
            snap_d       <= 16'd0;
            snap_l       <= 16'd0;
            gtx_loopback <= 3'b000;
            aborted      <= 1'b0;
            pass_mask    <= 4'b0000;
            tested_mask  <= 4'b0000;
            err_res      <= 64'd0;
        end else if (abort && active) begin
            // The slot in progress is dropped; earlier slots keep their results.
            aborted      <= 1'b1;
            gtx_loopback <= 3'b000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        idx         <= 3'd0;
                        aborted     <= 1'b0;
                        pass_mask   <= 4'b0000;
                        tested_mask <= 4'b0000;
                        err_res     <= 64'd0;
                    end
                end
                S_SELECT: begin
                    if (idx[2]) begin
                        gtx_loopback <= 3'b000;
                    end else if (!mode_en[idx[1:0]]) begin
                        idx <= idx + 3'd1;
                    end else begin
                        gtx_loopback <= slot_mode;
                        timer        <= 32'd0;
                    end
                end
                S_SETTLE, S_WINDOW: timer <= timer + 32'd1;
                S_SNAP: begin
                    snap_d <= data_err_cnt;
                    snap_l <= link_err_cnt;
                    timer  <= 32'd0;
                end
                S_EVAL: begin
                    err_res[{idx[1:0], 4'b0000} +: 16] <= d_delta;
                    pass_mask[idx[1:0]]   <= (d_delta <= err_thresh) && (l_delta == 16'd0);
                    tested_mask[idx[1:0]] <= 1'b1;
                    idx                   <= idx + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
